// File: rtl/node_list_builder.sv
// node_list_builder: clears the node-head RAM, then links both terminals of every element into per-node edge lists.
module node_list_builder #(
    parameter int ADDR_W = 5,
    parameter int ELEM_W = 32,
    parameter int VAL_W  = 32,
    parameter int RD_LAT = 2,
    localparam int EA_W   = ADDR_W + 1,
    localparam int HEAD_W = 1 + 3 * EA_W,
    localparam int EDGE_W = 1 + EA_W + 1 + 2 * ADDR_W + 2 + VAL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [EA_W-1:0]   num_elements,
    input  logic [ADDR_W-1:0] max_node,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_elem,
    output logic [EA_W-1:0]   num_nodes,
    output logic [EA_W:0]     num_edges,
    output logic [ADDR_W-1:0] elem_addr,
    input  logic [ELEM_W-1:0] elem_rdata,
    input  logic [VAL_W-1:0]  val_rdata,
    output logic [ADDR_W-1:0] head_addr,
    output logic [HEAD_W-1:0] head_wdata,
    output logic              head_wren,
    input  logic [HEAD_W-1:0] head_rdata,
    output logic [EA_W-1:0]   edge_addr,
    output logic [EDGE_W-1:0] edge_wdata,
    output logic              edge_wren,
    input  logic [EDGE_W-1:0] edge_rdata
);
    localparam int CNT_W = ADDR_W > $clog2(RD_LAT) + 1 ? ADDR_W : $clog2(RD_LAT) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_HEAD_RD, S_NEW, S_TAIL_RD, S_LINK, S_APPEND, S_DONE, S_ERR
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] k_q, k_d, max_q, max_d, err_elem_q, err_elem_d;
    logic [EA_W-1:0] nel_q, nel_d, num_nodes_q, num_nodes_d;
    logic [EA_W:0] num_edges_q, num_edges_d;
    logic side_q, side_d, done_q, done_d, error_q, error_d;
    logic [1:0] err_code_q, err_code_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    logic [ADDR_W-1:0] ra, rb, ea, eb, node, other;
    logic [1:0] etype;
    logic [EA_W-1:0] e, h_head, h_tail, h_deg, deg_inc;
    logic [EDGE_W-1:0] new_edge;
    logic last_rd, last_elem, unused_bits;
    state_t side_next;

    assign ra = elem_rdata[ELEM_W-1 -: ADDR_W];
    assign rb = elem_rdata[ELEM_W-1-ADDR_W -: ADDR_W];
    assign ea = elem_q[ELEM_W-1 -: ADDR_W];
    assign eb = elem_q[ELEM_W-1-ADDR_W -: ADDR_W];
    assign etype = elem_q[ELEM_W-1-2*ADDR_W -: 2];
    assign node = side_q ? eb : ea;
    assign other = side_q ? ea : eb;
    assign e = {k_q, side_q};
    assign {h_head, h_tail, h_deg} = head_q[HEAD_W-2:0];
    assign deg_inc = &h_deg ? h_deg : h_deg + EA_W'(1);
    assign new_edge = {1'b1, {EA_W{1'b0}}, side_q, other, node, etype, val_q};
    assign last_rd = cnt_q == CNT_W'(RD_LAT - 1);
    assign last_elem = ({1'b0, k_q} + EA_W'(1)) == nel_q;
    assign side_next = !side_q ? S_HEAD_RD : last_elem ? S_DONE : S_FETCH;
    assign unused_bits = ^{elem_q, edge_q[EDGE_W-1 -: EA_W+1], head_q[HEAD_W-1]};

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        k_d = k_q;
        max_d = max_q;
        err_elem_d = err_elem_q;
        nel_d = nel_q;
        num_nodes_d = num_nodes_q;
        num_edges_d = num_edges_q;
        side_d = side_q;
        done_d = done_q;
        error_d = error_q;
        err_code_d = err_code_q;
        elem_d = elem_q;
        val_d = val_q;
        head_d = head_q;
        edge_d = edge_q;
        elem_addr = '0;
        head_addr = '0;
        head_wdata = '0;
        head_wren = 1'b0;
        edge_addr = '0;
        edge_wdata = '0;
        edge_wren = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                done_d = 1'b0;
                error_d = 1'b0;
                err_code_d = 2'd0;
                err_elem_d = '0;
                num_nodes_d = '0;
                num_edges_d = '0;
                nel_d = num_elements;
                max_d = max_node;
                cnt_d = '0;
                k_d = '0;
                side_d = 1'b0;
                err_code_d = (num_elements[EA_W-1] && |num_elements[ADDR_W-1:0]) ? 2'd3 : 2'd0;
                state_d = (num_elements[EA_W-1] && |num_elements[ADDR_W-1:0]) ? S_ERR : S_CLEAR;
            end
            S_CLEAR: begin
                head_addr = cnt_q[ADDR_W-1:0];
                head_wren = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(2**ADDR_W - 1)) begin
                    cnt_d = '0;
                    state_d = nel_q == '0 ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                elem_addr = k_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_rd) begin
                    cnt_d = '0;
                    elem_d = elem_rdata;
                    val_d = val_rdata;
                    side_d = 1'b0;
                    state_d = S_HEAD_RD;
                    if (ra > max_q || rb > max_q || ra == rb) begin
                        err_code_d = (ra > max_q || rb > max_q) ? 2'd1 : 2'd2;
                        err_elem_d = k_q;
                        state_d = S_ERR;
                    end
                end
            end
            S_HEAD_RD: begin
                head_addr = node;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_rd) begin
                    cnt_d = '0;
                    head_d = head_rdata;
                    state_d = head_rdata[HEAD_W-1] ? S_TAIL_RD : S_NEW;
                end
            end
            S_NEW: begin
                head_addr = node;
                head_wdata = {1'b1, e, e, EA_W'(1)};
                head_wren = 1'b1;
                edge_addr = e;
                edge_wdata = new_edge;
                edge_wren = 1'b1;
                num_nodes_d = num_nodes_q + EA_W'(1);
                num_edges_d = num_edges_q + (EA_W+1)'(1);
                side_d = ~side_q;
                k_d = (side_q && !last_elem) ? k_q + ADDR_W'(1) : k_q;
                state_d = side_next;
            end
            S_TAIL_RD: begin
                edge_addr = h_tail;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_rd) begin
                    cnt_d = '0;
                    edge_d = edge_rdata;
                    state_d = S_LINK;
                end
            end
            S_LINK: begin
                edge_addr = h_tail;
                edge_wdata = {1'b0, e, edge_q[EDGE_W-2-EA_W:0]};
                edge_wren = 1'b1;
                head_addr = node;
                head_wdata = {1'b1, h_head, e, deg_inc};
                head_wren = 1'b1;
                state_d = S_APPEND;
            end
            S_APPEND: begin
                edge_addr = e;
                edge_wdata = new_edge;
                edge_wren = 1'b1;
                num_edges_d = num_edges_q + (EA_W+1)'(1);
                side_d = ~side_q;
                k_d = (side_q && !last_elem) ? k_q + ADDR_W'(1) : k_q;
                state_d = side_next;
            end
            default: state_d = S_IDLE;
        endcase
        // done/error rise on the same edge that leaves the busy states
        if (state_d == S_DONE) done_d = 1'b1;
        if (state_d == S_ERR) error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            k_q <= '0;
            max_q <= '0;
            err_elem_q <= '0;
            nel_q <= '0;
            num_nodes_q <= '0;
            num_edges_q <= '0;
            side_q <= 1'b0;
            done_q <= 1'b0;
            error_q <= 1'b0;
            err_code_q <= 2'd0;
            elem_q <= '0;
            val_q <= '0;
            head_q <= '0;
            edge_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            k_q <= k_d;
            max_q <= max_d;
            err_elem_q <= err_elem_d;
            nel_q <= nel_d;
            num_nodes_q <= num_nodes_d;
            num_edges_q <= num_edges_d;
            side_q <= side_d;
            done_q <= done_d;
            error_q <= error_d;
            err_code_q <= err_code_d;
            elem_q <= elem_d;
            val_q <= val_d;
            head_q <= head_d;
            edge_q <= edge_d;
        end
    end

    assign busy = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign done = done_q;
    assign error = error_q;
    assign err_code = err_code_q;
    assign err_elem = err_elem_q;
    assign num_nodes = num_nodes_q;
    assign num_edges = num_edges_q;
endmodule
